fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, giving the maximum instruction-memory wait cycles before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Z, input, 1, branch taken, resolved in EX.
REQ-005 SHALL have port JR, input, 1, jump-register decoded in ID.
REQ-006 SHALL have port J, input, 1, jump decoded in ID.
REQ-007 SHALL have port load_use, input, 1, load-use hazard detected on the ID instruction.
REQ-008 SHALL have port imem_ready, input, 1, instruction-memory data valid this cycle.
REQ-009 SHALL have port pc_sel, output, 2, PC mux select: 00 NextPC, 01 BranchAddr, 10 JumpAddr, 11 JrAddr.
REQ-010 SHALL have port PC_IFWrite, output, 1, PC register enable.
REQ-011 SHALL have ports IFID_Write and IFID_Flush, output, 1 each, IF/ID register enable and clear.
REQ-012 SHALL have port IDEX_Flush, output, 1, ID/EX bubble insert.
REQ-013 SHALL have port imem_abort, output, 1, one-cycle pulse cancelling the outstanding fetch.
REQ-014 SHALL have port fetch_err, output, 1, sticky timeout flag.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, 16 each, saturating performance counters.

Function
REQ-016 SHALL implement states HOLD, RUN and MEMWAIT; outputs are combinational from state and inputs unless stated.
REQ-017 SHALL, in HOLD, drive PC_IFWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1 and pc_sel=00, then go to RUN after exactly 1 cycle.
REQ-018 SHALL resolve events in RUN and MEMWAIT with priority Z > load_use > JR > J > memory wait.
REQ-019 SHALL, on Z=1, drive pc_sel=01, PC_IFWrite=1, IFID_Flush=1, IDEX_Flush=1, and increment flush_cnt by 1.
REQ-020 SHALL, on load_use=1 with Z=0, drive PC_IFWrite=0, IFID_Write=0 and IDEX_Flush=1, hold IFID_Flush=0, and increment stall_cnt; JR and J are ignored that cycle.
REQ-021 SHALL, on JR=1 (or J=1 with JR=0) with Z=0 and load_use=0, drive pc_sel=11 (10 for J), PC_IFWrite=1, IFID_Flush=1 and IDEX_Flush=0, and increment flush_cnt.
REQ-022 SHALL, on any redirect (REQ-019/021) taken in MEMWAIT, pulse imem_abort=1, clear the wait counter and go to RUN.
REQ-023 SHALL, in RUN with no event and imem_ready=1, drive pc_sel=00, PC_IFWrite=1 and IFID_Write=1, with all flushes 0.
REQ-024 SHALL, in RUN with no event and imem_ready=0, drive PC_IFWrite=0, IFID_Write=0 and IFID_Flush=1, increment stall_cnt, load wait counter to 1 and go to MEMWAIT.
REQ-025 SHALL, in MEMWAIT with no event, hold PC (PC_IFWrite=0), keep IFID_Flush=1, increment stall_cnt and the 8-bit wait counter each cycle.
REQ-026 SHALL, in MEMWAIT with imem_ready=1 and no event, behave as REQ-023 in the same cycle and go to RUN.
REQ-027 SHALL, in MEMWAIT when the wait counter equals TIMEOUT and imem_ready=0, pulse imem_abort, set fetch_err=1, clear the wait counter and go to RUN (PC held, so fetch retries).
REQ-028 SHALL, when a load_use stall occurs in MEMWAIT, remain in MEMWAIT and keep counting the wait.
REQ-029 SHALL saturate stall_cnt and flush_cnt at 16'hFFFF without wrap.
REQ-030 SHALL keep fetch_err set until reset.
REQ-031 SHALL never assert PC_IFWrite and IFID_Write both 0 together with IFID_Flush=0 and IDEX_Flush=0 except under load_use.

Reset
REQ-032 SHALL, while reset=1, force state to HOLD, drive the HOLD outputs of REQ-017, drive imem_abort=0, and clear fetch_err, the wait counter, stall_cnt and flush_cnt at the clock edge.
REQ-033 SHALL, on reset asserted mid-MEMWAIT, discard the wait without imem_abort and restart from HOLD.

Verification
REQ-034 SHALL be covered by: reset held 2 cycles, released, imem_ready=1 -> HOLD 1 cycle (PC_IFWrite=0, IFID_Flush=1), then PC_IFWrite=1 and pc_sel=00 every cycle.
REQ-035 SHALL be covered by: Z=1, JR=1 and load_use=1 in the same RUN cycle -> pc_sel=01, IFID_Flush=1, IDEX_Flush=1, flush_cnt +1, stall_cnt unchanged.
REQ-036 SHALL be covered by: load_use=1 for 1 cycle with J=1 -> PC_IFWrite=0 and IDEX_Flush=1; next cycle with load_use=0 and J=1 -> pc_sel=10 and IFID_Flush=1.
REQ-037 SHALL be covered by: imem_ready=0 for 3 cycles then 1 -> 3 hold cycles with stall_cnt=3, then a PC_IFWrite=1 cycle in RUN.
REQ-038 SHALL be covered by: TIMEOUT=4 and imem_ready stuck 0 -> imem_abort pulses at wait count 4, fetch_err=1 stays set, and a new wait starts.
REQ-039 SHALL be covered by: flush_cnt preloaded near max via 65536+ redirects -> holds 16'hFFFF without wrap.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Pipeline fetch controller: arbitrates branch/jump redirects, load-use stalls and
// instruction-memory waits, with a timeout abort and saturating stall/flush counters.
module fetch_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Z,
  input  logic        JR,
  input  logic        J,
  input  logic        load_use,
  input  logic        imem_ready,
  output logic [1:0]  pc_sel,
  output logic        PC_IFWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        imem_abort,
  output logic        fetch_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       stall_inc, flush_inc, err_set;

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    pc_sel     = 2'b00;
    PC_IFWrite = 1'b0;
    IFID_Write = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    imem_abort = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    err_set    = 1'b0;
    if (reset) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      state_nxt  = HOLD;
      wait_nxt   = 8'd0;
    end else begin
      case (state)
        HOLD: begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
          state_nxt  = RUN;
          wait_nxt   = 8'd0;
        end
        RUN, MEMWAIT: begin
          if (Z || (!load_use && (JR || J))) begin
            // Redirect: a pending fetch from the old path is cancelled.
            pc_sel     = Z ? 2'b01 : (JR ? 2'b11 : 2'b10);
            PC_IFWrite = 1'b1;
            IFID_Flush = 1'b1;
            IDEX_Flush = Z;
            flush_inc  = 1'b1;
            imem_abort = (state == MEMWAIT);
            wait_nxt   = 8'd0;
            state_nxt  = RUN;
          end else if (load_use) begin
            // Wait keeps counting but parks at TIMEOUT so the abort still fires afterwards.
            IDEX_Flush = 1'b1;
            stall_inc  = 1'b1;
            if (state == MEMWAIT && wait_cnt != TIMEOUT)
              wait_nxt = wait_cnt + 8'd1;
          end else if (imem_ready) begin
            PC_IFWrite = 1'b1;
            IFID_Write = 1'b1;
            wait_nxt   = 8'd0;
            state_nxt  = RUN;
          end else begin
            IFID_Flush = 1'b1;
            stall_inc  = 1'b1;
            if (state == RUN) begin
              wait_nxt  = 8'd1;
              state_nxt = MEMWAIT;
            end else if (wait_cnt == TIMEOUT) begin
              imem_abort = 1'b1;
              err_set    = 1'b1;
              wait_nxt   = 8'd0;
              state_nxt  = RUN;
            end else begin
              wait_nxt = wait_cnt + 8'd1;
            end
          end
        end
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      wait_cnt  <= 8'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
      fetch_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (stall_inc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_inc && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
      if (err_set)
        fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (TIMEOUT=4): walks reset, redirects, stalls,
// memory waits, timeout abort, reset mid-wait and flush counter saturation.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, Z, JR, J, load_use, imem_ready;
  logic [1:0]  pc_sel;
  logic        PC_IFWrite, IFID_Write, IFID_Flush, IDEX_Flush, imem_abort, fetch_err;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_sel, PC_IFWrite, IFID_Write, IFID_Flush, IDEX_Flush, imem_abort}
  localparam logic [6:0] O_HOLD = 7'b00_0_0_1_1_0;
  localparam logic [6:0] O_RUN  = 7'b00_1_1_0_0_0;
  localparam logic [6:0] O_WAIT = 7'b00_0_0_1_0_0;
  localparam logic [6:0] O_TOUT = 7'b00_0_0_1_0_1;
  localparam logic [6:0] O_BR   = 7'b01_1_0_1_1_0;
  localparam logic [6:0] O_BRA  = 7'b01_1_0_1_1_1;
  localparam logic [6:0] O_LU   = 7'b00_0_0_0_1_0;
  localparam logic [6:0] O_J    = 7'b10_1_0_1_0_0;

  fetch_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Z          (Z),
    .JR         (JR),
    .J          (J),
    .load_use   (load_use),
    .imem_ready (imem_ready),
    .pc_sel     (pc_sel),
    .PC_IFWrite (PC_IFWrite),
    .IFID_Write (IFID_Write),
    .IFID_Flush (IFID_Flush),
    .IDEX_Flush (IDEX_Flush),
    .imem_abort (imem_abort),
    .fetch_err  (fetch_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic z, input logic jr,
                               input logic j, input logic lu, input logic rdy);
    reset      = r;
    Z          = z;
    JR         = jr;
    J          = j;
    load_use   = lu;
    imem_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] exp_out);
    logic [6:0] obs;
    obs = {pc_sel, PC_IFWrite, IFID_Write, IFID_Flush, IDEX_Flush, imem_abort};
    checks++;
    assert (obs === exp_out) else begin
      errors++;
      $error("[TB] FAIL %s outputs observed=%b expected=%b", tag, obs, exp_out);
    end
  endtask

  task automatic checkCount(input string tag, input logic [15:0] exp_stall,
                            input logic [15:0] exp_flush, input logic exp_err);
    logic [32:0] obs, exp_v;
    obs   = {stall_cnt, flush_cnt, fetch_err};
    exp_v = {exp_stall, exp_flush, exp_err};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s stall/flush/err observed=%h/%h/%b expected=%h/%h/%b",
             tag, stall_cnt, flush_cnt, fetch_err, exp_stall, exp_flush, exp_err);
    end
  endtask

  // One cycle: drive, check combinational outputs mid-cycle, then check registers after the edge.
  task automatic step(input string tag, input logic r, input logic z, input logic jr,
                      input logic j, input logic lu, input logic rdy, input logic [6:0] exp_out,
                      input logic [15:0] exp_stall, input logic [15:0] exp_flush, input logic exp_err);
    applyStimulus(r, z, jr, j, lu, rdy);
    @(negedge clk);
    checkOutput(tag, exp_out);
    @(posedge clk);
    #1;
    checkCount(tag, exp_stall, exp_flush, exp_err);
  endtask

  initial begin
    step("rst0",      1, 0, 0, 0, 0, 1, O_HOLD, 16'd0, 16'd0, 0);
    step("rst1",      1, 0, 0, 0, 0, 1, O_HOLD, 16'd0, 16'd0, 0);
    step("hold",      0, 0, 0, 0, 0, 1, O_HOLD, 16'd0, 16'd0, 0);
    step("run0",      0, 0, 0, 0, 0, 1, O_RUN,  16'd0, 16'd0, 0);
    step("run1",      0, 0, 0, 0, 0, 1, O_RUN,  16'd0, 16'd0, 0);
    step("run2",      0, 0, 0, 0, 0, 1, O_RUN,  16'd0, 16'd0, 0);
    step("z_prio",    0, 1, 1, 0, 1, 1, O_BR,   16'd0, 16'd1, 0);
    step("lu_j",      0, 0, 0, 1, 1, 1, O_LU,   16'd1, 16'd1, 0);
    step("j_after",   0, 0, 0, 1, 0, 1, O_J,    16'd1, 16'd2, 0);
    step("mw_a0",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd2, 16'd2, 0);
    step("mw_a1",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd3, 16'd2, 0);
    step("mw_a2",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd4, 16'd2, 0);
    step("mw_ready",  0, 0, 0, 0, 0, 1, O_RUN,  16'd4, 16'd2, 0);
    step("run3",      0, 0, 0, 0, 0, 1, O_RUN,  16'd4, 16'd2, 0);
    step("mw_b0",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd5, 16'd2, 0);
    step("mw_br",     0, 1, 0, 0, 0, 0, O_BRA,  16'd5, 16'd3, 0);
    step("run4",      0, 0, 0, 0, 0, 1, O_RUN,  16'd5, 16'd3, 0);
    step("mw_c0",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd6, 16'd3, 0);
    step("mw_lu",     0, 0, 0, 0, 1, 0, O_LU,   16'd7, 16'd3, 0);
    step("mw_c2",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd8, 16'd3, 0);
    step("mw_c3",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd9, 16'd3, 0);
    step("tout1",     0, 0, 0, 0, 0, 0, O_TOUT, 16'd10, 16'd3, 1);
    step("retry_run", 0, 0, 0, 0, 0, 0, O_WAIT, 16'd11, 16'd3, 1);
    step("mw_d1",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd12, 16'd3, 1);
    step("mw_d2",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd13, 16'd3, 1);
    step("mw_d3",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd14, 16'd3, 1);
    step("tout2",     0, 0, 0, 0, 0, 0, O_TOUT, 16'd15, 16'd3, 1);
    step("run5",      0, 0, 0, 0, 0, 1, O_RUN,  16'd15, 16'd3, 1);
    step("mw_e0",     0, 0, 0, 0, 0, 0, O_WAIT, 16'd16, 16'd3, 1);
    step("rst_mw",    1, 0, 0, 0, 0, 0, O_HOLD, 16'd0, 16'd0, 0);
    step("hold2",     0, 0, 0, 0, 0, 1, O_HOLD, 16'd0, 16'd0, 0);
    step("run6",      0, 0, 0, 0, 0, 1, O_RUN,  16'd0, 16'd0, 0);

    applyStimulus(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    checkCount("flush_sat", 16'd0, 16'hFFFF, 0);
    step("flush_hold", 0, 1, 0, 0, 0, 1, O_BR, 16'd0, 16'hFFFF, 0);
    step("run7",       0, 0, 0, 0, 0, 1, O_RUN, 16'd0, 16'hFFFF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
